// File: rtl/sym_dn_lut_loader_if.sv
// Stream, swap-control and LUT write-port signals of the symmetric DN LUT loader.
// The master is the host/decoder side; the slave is the loader itself.
interface sym_dn_lut_loader_if #(
  parameter int unsigned PageAddrW = 6
);
  logic                 load_req;
  logic                 lut_valid;
  logic                 lut_ready;
  logic [1:0]           lut_data;
  logic                 swap_req;
  logic                 vnu_busy;
  logic                 read_addr_offset;
  logic                 lut_in_bank0;
  logic                 lut_in_bank1;
  logic [PageAddrW-1:0] page_write_addr;
  logic                 write_addr_offset;
  logic                 we;
  logic                 shadow_valid;
  logic                 load_done;
  logic                 swap_ack;
  logic                 load_err;

  modport master (
    output load_req, lut_valid, lut_data, swap_req, vnu_busy,
    input  lut_ready, read_addr_offset, lut_in_bank0, lut_in_bank1, page_write_addr,
    input  write_addr_offset, we, shadow_valid, load_done, swap_ack, load_err
  );

  modport slave (
    input  load_req, lut_valid, lut_data, swap_req, vnu_busy,
    output lut_ready, read_addr_offset, lut_in_bank0, lut_in_bank1, page_write_addr,
    output write_addr_offset, we, shadow_valid, load_done, swap_ack, load_err
  );
endinterface

// File: rtl/sym_dn_lut_loader.sv
// Double-buffer controller for the symmetric DN LUT rank memory: streams a LUT set into the
// shadow half and swaps the active half at an iteration boundary once reads are idle.
module sym_dn_lut_loader #(
  parameter int unsigned PageNum   = 64,
  parameter int unsigned PageAddrW = 6
) (
  input logic                clk_i,
  input logic                rst_ni,
  sym_dn_lut_loader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e               state_q;
  logic [PageAddrW-1:0] page_cnt_q;
  logic [PageAddrW-1:0] page_addr_q;
  logic                 rd_off_q;
  logic                 wr_off_q;
  logic                 we_q;
  logic                 bank0_q;
  logic                 bank1_q;
  logic                 shadow_valid_q;
  logic                 load_done_q;
  logic                 swap_ack_q;
  logic                 load_err_q;
  logic                 swap_pend_q;
  logic                 load_pend_q;

  logic accept;
  logic swap_fire;
  logic last_page;

  always_comb begin
    accept    = (state_q == StLoad) && bus.lut_valid;
    last_page = (page_cnt_q == PageAddrW'(PageNum - 1));
    // Swapping only from idle guarantees the active half is never being written.
    swap_fire = swap_pend_q && shadow_valid_q && !bus.vnu_busy && (state_q == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      page_cnt_q     <= '0;
      page_addr_q    <= '0;
      rd_off_q       <= 1'b0;
      wr_off_q       <= 1'b0;
      we_q           <= 1'b0;
      bank0_q        <= 1'b0;
      bank1_q        <= 1'b0;
      shadow_valid_q <= 1'b0;
      load_done_q    <= 1'b0;
      swap_ack_q     <= 1'b0;
      load_err_q     <= 1'b0;
      swap_pend_q    <= 1'b0;
      load_pend_q    <= 1'b0;
    end else begin
      we_q        <= accept;
      load_done_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      load_err_q  <= 1'b0;

      if (accept) begin
        page_addr_q <= page_cnt_q;
        wr_off_q    <= ~rd_off_q;
        bank0_q     <= bus.lut_data[0];
        bank1_q     <= bus.lut_data[1];
        page_cnt_q  <= page_cnt_q + PageAddrW'(1);
      end

      if (swap_fire) begin
        rd_off_q       <= ~rd_off_q;
        shadow_valid_q <= 1'b0;
        swap_pend_q    <= 1'b0;
        swap_ack_q     <= 1'b1;
      end else if (bus.swap_req) begin
        swap_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (swap_fire) begin
            // A load request colliding with the swap is deferred one cycle.
            if (bus.load_req) load_pend_q <= 1'b1;
          end else if (bus.load_req || load_pend_q) begin
            state_q        <= StLoad;
            page_cnt_q     <= '0;
            shadow_valid_q <= 1'b0;
            load_pend_q    <= 1'b0;
          end
        end
        StLoad: begin
          if (bus.load_req) load_err_q <= 1'b1;
          if (accept && last_page) state_q <= StDone;
        end
        StDone: begin
          if (bus.load_req) load_err_q <= 1'b1;
          shadow_valid_q <= 1'b1;
          load_done_q    <= 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.lut_ready         = (state_q == StLoad);
  assign bus.read_addr_offset  = rd_off_q;
  assign bus.write_addr_offset = wr_off_q;
  assign bus.page_write_addr   = page_addr_q;
  assign bus.we                = we_q;
  assign bus.lut_in_bank0      = bank0_q;
  assign bus.lut_in_bank1      = bank1_q;
  assign bus.shadow_valid      = shadow_valid_q;
  assign bus.load_done         = load_done_q;
  assign bus.swap_ack          = swap_ack_q;
  assign bus.load_err          = load_err_q;

endmodule
